shift_issue_stage: RTL and testbench

SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

---
 rtl/alu_shift_pkg.sv | 22 ++
 rtl/shift_req_fifo.sv | 64 ++++++
 rtl/shift_issue_stage.sv | 90 +++++++++
 tb/tb_shift_issue_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared opcodes, widths and the shift request record for the shift issue path.
package alu_shift_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned AMT_W  = 5;
   localparam int unsigned OP_W   = 5;
   localparam int unsigned CNT_W  = 16;

   localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
   localparam logic [OP_W-1:0] OP_SRA = 5'b00101;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
      logic              arith;
   } shift_req_t;

   function automatic logic is_shift_op(input logic [OP_W-1:0] op);
      return (op == OP_SLL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/shift_req_fifo.sv
// Small FIFO of shift requests; head is read straight from storage, flush
// empties it synchronously and overrides push/pop.
module shift_req_fifo
   import alu_shift_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       push,
   input  shift_req_t push_req,
   input  logic       pop,
   input  logic       flush,
   output logic       full,
   output logic       empty,
   output shift_req_t head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] count;
   shift_req_t       mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (count == OCC_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_req;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes SLL/SRA requests into a FIFO and issues them in
// order. Optional issue counter enabled by SHIFT_ISSUE_COUNT_EN.
module shift_issue_stage
   import alu_shift_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_shamt,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_amt,
   output logic        out_arith,
   output logic        illegal_op,
   output logic [15:0] issue_count
);

   logic       full;
   logic       empty;
   logic       accept;
   logic       legal;
   logic       push;
   logic       pop;
   shift_req_t push_req;
   shift_req_t head;

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign accept    = in_valid && in_ready;
   assign legal     = is_shift_op(in_op);
   assign push      = accept && legal;
   assign pop       = out_valid && out_ready;

   assign push_req.data  = in_data;
   assign push_req.amt   = in_shamt;
   assign push_req.arith = (in_op == OP_SRA);

   assign out_data  = head.data;
   assign out_amt   = head.amt;
   assign out_arith = head.arith;

   shift_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (push),
      .push_req (push_req),
      .pop      (pop),
      .flush    (flush),
      .full     (full),
      .empty    (empty),
      .head     (head)
   );

   // Dropped non-shift opcode pulses for one cycle, masked by flush.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= accept && !legal && !flush;
      end
   end

`ifdef SHIFT_ISSUE_COUNT_EN
   logic             issue;
   logic [CNT_W-1:0] issue_cnt;

   assign issue = pop && !flush;

   // Saturating count of issued requests; only reset clears it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         issue_cnt <= '0;
      end else if (issue && (issue_cnt != '1)) begin
         issue_cnt <= issue_cnt + CNT_W'(1);
      end
   end

   assign issue_count = issue_cnt;
`else
   assign issue_count = '0;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage (DEPTH = 2).
module tb_shift_issue_stage;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_amt;
   logic        out_arith;
   logic        illegal_op;
   logic [15:0] issue_count;

   int checks   = 0;
   int failures = 0;

   shift_issue_stage #(.DEPTH(2)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_data     (in_data),
      .in_shamt    (in_shamt),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_amt     (out_amt),
      .out_arith   (out_arith),
      .illegal_op  (illegal_op),
      .issue_count (issue_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] d, input logic [4:0] a);
      in_valid = v;
      in_op    = op;
      in_data  = d;
      in_shamt = a;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"},  out_data, 32'd0);
      check({tag, "_out_amt"},   32'(out_amt), 32'd0);
      check({tag, "_out_arith"}, 32'(out_arith), 32'd0);
      check({tag, "_illegal"},   32'(illegal_op), 32'd0);
      check({tag, "_count"},     32'(issue_count), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      #12;
      check_reset_vals("reset");
      @(negedge clock);
      reset_n = 1'b1;
      #1;

      // Single SLL request, latency one, then issue
      drive(1'b1, 5'b00100, 32'h0000_0001, 5'd4);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data",  out_data, 32'h1);
      check("t1_amt",   32'(out_amt), 32'd4);
      check("t1_arith", 32'(out_arith), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1_empty", 32'(out_valid), 32'd0);

      // Fill with out_ready low; third request held until space frees
      drive(1'b1, 5'b00101, 32'h8000_0000, 5'd3);
      tick();
      check("t2_ready_1", 32'(in_ready), 32'd1);
      drive(1'b1, 5'b00100, 32'h0000_00AA, 5'd1);
      tick();
      check("t2_full", 32'(in_ready), 32'd0);
      drive(1'b1, 5'b00100, 32'h0000_0055, 5'd2);
      tick();
      check("t2_held_ready", 32'(in_ready), 32'd0);
      check("t2_head_a",     out_data, 32'h8000_0000);
      check("t2_head_a_ar",  32'(out_arith), 32'd1);
      check("t2_head_a_amt", 32'(out_amt), 32'd3);
      out_ready = 1'b1;
      tick();
      check("t2_head_b", out_data, 32'h0000_00AA);
      check("t2_b_ready", 32'(in_ready), 32'd1);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      check("t2_head_c",   out_data, 32'h0000_0055);
      check("t2_c_amt",    32'(out_amt), 32'd2);
      check("t2_c_valid",  32'(out_valid), 32'd1);
      tick();
      out_ready = 1'b0;
      check("t2_empty", 32'(out_valid), 32'd0);

      // Non-shift opcode is dropped with a one-cycle pulse
      drive(1'b1, 5'b00000, 32'h1234_5678, 5'd7);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      check("t3_illegal_hi", 32'(illegal_op), 32'd1);
      check("t3_no_valid",   32'(out_valid), 32'd0);
      tick();
      check("t3_illegal_lo", 32'(illegal_op), 32'd0);
      check("t3_no_valid2",  32'(out_valid), 32'd0);

      // Occupancy one with simultaneous push and issue, crossing pointer wrap
      drive(1'b1, 5'b00100, 32'd100, 5'd0);
      tick();
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, (i % 2 == 1) ? 5'b00101 : 5'b00100, 32'd100 + 32'(i), 5'(i));
         tick();
         check($sformatf("t4_head_%0d", i),  out_data, 32'd100 + 32'(i));
         check($sformatf("t4_arith_%0d", i), 32'(out_arith), (i % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("t4_occ_%0d", i),   32'({out_valid, in_ready}), 32'b11);
      end
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      tick();
      out_ready = 1'b0;
      check("t4_empty", 32'(out_valid), 32'd0);
`ifdef SHIFT_ISSUE_COUNT_EN
      check("t4_count", 32'(issue_count), 32'd15);
`else
      check("t4_count", 32'(issue_count), 32'd0);
`endif

      // Flush while full overrides a same-cycle push and issue
      drive(1'b1, 5'b00100, 32'h0000_0011, 5'd1);
      tick();
      drive(1'b1, 5'b00101, 32'h0000_0022, 5'd2);
      tick();
      check("t5_full", 32'(in_ready), 32'd0);
      drive(1'b1, 5'b00100, 32'h0000_DEAD, 5'd5);
      flush     = 1'b1;
      out_ready = 1'b1;
      tick();
      check("t5_flushed", 32'(out_valid), 32'd0);
      check("t5_ready",   32'(in_ready), 32'd1);
      // Flush also masks illegal_op and drops the push
      drive(1'b1, 5'b00011, 32'h0, 5'd0);
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      check("t5_no_illegal", 32'(illegal_op), 32'd0);
      check("t5_still_empty", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-stream
      drive(1'b1, 5'b00101, 32'hCAFE_F00D, 5'd9);
      tick();
      drive(1'b1, 5'b00100, 32'h0BAD_BEEF, 5'd8);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      check("t6_full", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_vals("t6_async");
      tick();
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t6_after_valid", 32'(out_valid), 32'd0);
      check("t6_after_count", 32'(issue_count), 32'd0);

`ifdef SHIFT_ISSUE_COUNT_EN
      // Counter saturates at 16'hFFFF
      force dut.issue_cnt = 16'hFFFE;
      #1;
      release dut.issue_cnt;
      out_ready = 1'b1;
      drive(1'b1, 5'b00100, 32'h1, 5'd1);
      repeat (4) tick();
      drive(1'b0, 5'd0, 32'd0, 5'd0);
      out_ready = 1'b0;
      check("t7_saturate", 32'(issue_count), 32'h0000_FFFF);
`else
      check("t7_tied_zero", 32'(issue_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
